// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between instruction fetch (IF) and
// data memory access (DM). A four-state FSM (IDLE, BUSY_IF, BUSY_DM, DONE)
// holds a transaction on the memory port until mem_ready, then returns the
// response to its owner as a one-cycle valid pulse. DM has fixed priority over
// IF. A flush during a fetch lets the memory transaction finish but discards
// its response. A BUSY phase that waits TIMEOUT cycles without mem_ready is
// aborted, sets the sticky err flag and still completes with rdata = 0.
//
// Optional build macro: MEM_ARB_PERF_EN adds two saturating 16-bit counters
// (perf_conflict, perf_wait). Without it those ports do not exist.
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  asynchronous active-low reset
//   if_req / if_addr     fetch request, held until if_valid
//   if_rdata / if_valid  registered fetch data, one-cycle completion pulse
//   if_stall             if_req & ~if_valid
//   dm_req / dm_we / dm_addr / dm_wdata   data request, held until dm_valid
//   dm_rdata / dm_valid  registered load data, one-cycle completion pulse
//   dm_stall             dm_req & ~dm_valid
//   flush                branch/jump taken, cancels an in-flight fetch
//   mem_req/mem_we/mem_addr/mem_wdata     memory request side
//   mem_rdata/mem_ready  memory response side (mem_ready is a 1-cycle ack)
//   err                  sticky timeout flag, cleared only by reset
//   perf_conflict/perf_wait (MEM_ARB_PERF_EN only) performance counters
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  input  logic          flush,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_conflict,
  output logic [15:0]   perf_wait
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Last waiting cycle before abort: the counter starts at 0 on entry to BUSY,
  // so seeing TIMEOUT-1 without mem_ready means TIMEOUT cycles have elapsed.
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;

  logic          r_owner;     // 1 = DM owns the current transaction, 0 = IF
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_mem_req;
  logic          r_kill;
  logic [3:0]    r_to_cnt;
  logic          r_err;
  logic          r_if_valid;
  logic          r_dm_valid;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  logic          w_busy;
  logic          w_accept_dm;
  logic          w_accept_if;
  logic          w_finish;    // BUSY ends this cycle (ack or timeout)
  logic          w_timeout;
  logic          w_drop;      // killed fetch: finish without a response
  logic          w_set_kill;
  logic [DW-1:0] w_rdata_cap;

  assign w_busy = (r_state == S_BUSY_IF) || (r_state == S_BUSY_DM);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept_dm  = 1'b0;
    w_accept_if  = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    w_drop       = 1'b0;
    w_set_kill   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dm_req) begin
          w_accept_dm  = 1'b1;
          w_state_next = S_BUSY_DM;
        end else if (if_req) begin
          w_accept_if  = 1'b1;
          w_set_kill   = flush;
          w_state_next = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_ready) begin
          w_finish = 1'b1;
        end else if (r_to_cnt == TO_LAST) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
        end
        if ((r_state == S_BUSY_IF) && flush) begin
          w_set_kill = 1'b1;
        end
        if (w_finish) begin
          // A flush in the very cycle the fetch completes also cancels it.
          if ((r_state == S_BUSY_IF) && (r_kill || flush)) begin
            w_drop       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        // No acceptance here so a still-held req is not serviced twice.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // DM writes return zero; an aborted transaction returns zero for anyone.
  assign w_rdata_cap = (w_timeout || (r_owner && r_we)) ? '0 : mem_rdata;

  // ---------------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_req  <= 1'b0;
      r_kill     <= 1'b0;
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_accept_dm) begin
        r_owner <= 1'b1;
        r_we    <= dm_we;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
      end else if (w_accept_if) begin
        r_owner <= 1'b0;
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
      end

      r_mem_req <= (w_state_next == S_BUSY_IF) || (w_state_next == S_BUSY_DM);

      if (w_state_next == S_IDLE) begin
        r_kill <= 1'b0;
      end else if (w_set_kill) begin
        r_kill <= 1'b1;
      end

      if (w_accept_dm || w_accept_if) begin
        r_to_cnt <= '0;
      end else if (w_busy && !w_finish) begin
        r_to_cnt <= r_to_cnt + 4'd1;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end

      // Valid is registered so it lines up with the DONE state.
      r_if_valid <= w_finish && !w_drop && !r_owner;
      r_dm_valid <= w_finish && r_owner;

      if (w_finish && !w_drop) begin
        if (r_owner) begin
          r_dm_rdata <= w_rdata_cap;
        end else begin
          r_if_rdata <= w_rdata_cap;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_we && r_mem_req;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_valid  = r_if_valid;
  assign dm_valid  = r_dm_valid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_stall  = if_req && !r_if_valid;
  assign dm_stall  = dm_req && !r_dm_valid;
  assign err       = r_err;

  // ---------------------------------------------------------------------------
  // Optional performance counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_perf_conflict;
  logic [15:0] r_perf_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_conflict <= '0;
      r_perf_wait     <= '0;
    end else begin
      if ((r_state == S_IDLE) && if_req && dm_req && (r_perf_conflict != 16'hFFFF)) begin
        r_perf_conflict <= r_perf_conflict + 16'd1;
      end
      if ((if_stall || dm_stall) && (r_perf_wait != 16'hFFFF)) begin
        r_perf_wait <= r_perf_wait + 16'd1;
      end
    end
  end

  assign perf_conflict = r_perf_conflict;
  assign perf_wait     = r_perf_wait;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A table of per-cycle records (inputs
// plus hand-computed expected outputs) covers fetch alone, DM/IF tie, DM write
// and flushed fetch. Hand-written sequences cover the timeout abort and an
// asynchronous reset in the middle of a DM transaction.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          dm_stall;
  logic          flush;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]   perf_conflict;
  logic [15:0]   perf_wait;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .dm_stall  (dm_stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflict (perf_conflict),
    .perf_wait     (perf_wait)
`endif
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic        e_ifv;
    logic [31:0] e_ifr;
    logic        e_ifs;
    logic        e_dmv;
    logic [31:0] e_dmr;
    logic        e_dms;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic fl, input logic mr, input logic [31:0] md,
    input logic emq, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
    input logic eiv, input logic [31:0] eir, input logic eis,
    input logic edv, input logic [31:0] edr, input logic eds);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;
    v.dm_req = dr;  v.dm_we = dw;  v.dm_addr = da;  v.dm_wdata = dd;
    v.flush = fl;   v.mem_ready = mr;  v.mem_rdata = md;
    v.e_mreq = emq; v.e_mwe = emw; v.e_maddr = ema; v.e_mwd = emd;
    v.e_ifv = eiv;  v.e_ifr = eir; v.e_ifs = eis;
    v.e_dmv = edv;  v.e_dmr = edr; v.e_dms = eds;
    return v;
  endfunction

  task automatic set_in(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic fl, input logic mr,
                        input logic [31:0] md);
    if_req = ir;  if_addr = ia;
    dm_req = dr;  dm_we = dw;  dm_addr = da;  dm_wdata = dd;
    flush = fl;   mem_ready = mr;  mem_rdata = md;
  endtask

  task automatic step_in(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic fl, input logic mr,
                         input logic [31:0] md);
    @(posedge clk);
    #1;
    set_in(ir, ia, dr, dw, da, dd, fl, mr, md);
    @(negedge clk);
  endtask

  initial begin
    // ---------------- vector table ----------------
    //         if_req addr   dm  we addr      wdata         fl rdy rdata          mreq we maddr     mwdata        ifv ifr           ifs dmv dmr           dms
    // 1: fetch alone
    vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00500093, 1, 0, 32'h100,  32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        1, 32'h00500093, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        0));
    // 2: tie, DM first then IF
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 32'h0,        0, 1, 32'h11112222, 1, 0, 32'h2000, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h104, 1, 0, 32'h2000, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 1, 32'h11112222, 0));
    vecs.push_back(mk(1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 1, 32'h33334444, 1, 0, 32'h104,  32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        1, 32'h33334444, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        0));
    // 3: DM write, one wait cycle, read data on the bus must be ignored
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'h2004, 32'hCAFEF00D, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'h2004, 32'hCAFEF00D, 0, 0, 32'h0,        1, 1, 32'h2004, 32'hCAFEF00D, 0, 32'h0,        0, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'h2004, 32'hCAFEF00D, 0, 1, 32'hDEADBEEF, 1, 1, 32'h2004, 32'hCAFEF00D, 0, 32'h0,        0, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'h2004, 32'hCAFEF00D, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 1, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        0));
    // 4: flushed fetch, then a normal fetch to 0x200
    vecs.push_back(mk(1, 32'h108, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h108, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 0, 32'h108,  32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        1, 0, 32'h108,  32'h0,        0, 32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 1, 32'h55555555, 1, 0, 32'h108,  32'h0,        0, 32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0,    32'h0,        0, 1, 32'h66667777, 1, 0, 32'h200,  32'h0,        0, 32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        1, 32'h66667777, 0, 0, 32'h0,        0));
    // mem_ready in IDLE is ignored
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 1, 32'h12345678, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 32'h0,        0));

    // ---------------- reset ----------------
    rst = 1'b0;
    set_in(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_mem_req",  mem_req,  1'b0);
    chk("reset_if_valid", if_valid, 1'b0);
    chk("reset_dm_valid", dm_valid, 1'b0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_dm_rdata", dm_rdata, 32'h0);
    chk("reset_err",      err,      1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    rst = 1'b1;

    // ---------------- table-driven part ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      set_in(vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_req, vecs[i].dm_we,
             vecs[i].dm_addr, vecs[i].dm_wdata, vecs[i].flush,
             vecs[i].mem_ready, vecs[i].mem_rdata);
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i),  mem_req,  vecs[i].e_mreq);
      chk($sformatf("v%0d_if_valid", i), if_valid, vecs[i].e_ifv);
      chk($sformatf("v%0d_if_stall", i), if_stall, vecs[i].e_ifs);
      chk($sformatf("v%0d_dm_valid", i), dm_valid, vecs[i].e_dmv);
      chk($sformatf("v%0d_dm_stall", i), dm_stall, vecs[i].e_dms);
      chk($sformatf("v%0d_err", i),      err,      1'b0);
      if (vecs[i].e_mreq) begin
        chk($sformatf("v%0d_mem_we", i),    mem_we,    vecs[i].e_mwe);
        chk($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].e_maddr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwd);
      end
      if (vecs[i].e_ifv) begin
        chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_ifr);
      end
      if (vecs[i].e_dmv) begin
        chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].e_dmr);
      end
      $display("vec %0d: mem_req=%0b mem_addr=0x%08h if_valid=%0b dm_valid=%0b", i, mem_req, mem_addr, if_valid, dm_valid);
    end

    // ---------------- timeout: DM read, mem_ready never comes ----------------
    step_in(0, 32'h0, 1, 0, 32'h3000, 32'h0, 0, 0, 32'h0);
    chk("to_c0_mem_req", mem_req, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      step_in(0, 32'h0, 1, 0, 32'h3000, 32'h0, 0, 0, 32'h0);
      chk($sformatf("to_c%0d_mem_req", c), mem_req, 1'b1);
      chk($sformatf("to_c%0d_err", c),     err,     1'b0);
    end
    step_in(0, 32'h0, 1, 0, 32'h3000, 32'h0, 0, 0, 32'h0);
    chk("to_c16_mem_req",  mem_req,  1'b0);
    chk("to_c16_dm_valid", dm_valid, 1'b1);
    chk("to_c16_dm_rdata", dm_rdata, 32'h0);
    chk("to_c16_err",      err,      1'b1);
    $display("timeout: err=%0b dm_valid=%0b dm_rdata=0x%08h", err, dm_valid, dm_rdata);
    for (int c = 17; c <= 19; c++) begin
      step_in(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
      chk($sformatf("to_c%0d_err_sticky", c), err,      1'b1);
      chk($sformatf("to_c%0d_dm_valid", c),   dm_valid, 1'b0);
    end

    // ---------------- async reset in the middle of BUSY_DM ----------------
    step_in(0, 32'h0, 1, 0, 32'h4000, 32'h0, 0, 0, 32'h0);
    chk("rst_c0_mem_req", mem_req, 1'b0);
    step_in(0, 32'h0, 1, 0, 32'h4000, 32'h0, 0, 0, 32'h0);
    chk("rst_c1_mem_req", mem_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_mem_req",  mem_req,  1'b0);
    chk("rst_async_dm_valid", dm_valid, 1'b0);
    chk("rst_async_if_valid", if_valid, 1'b0);
    chk("rst_async_err",      err,      1'b0);
    $display("async reset: mem_req=%0b err=%0b", mem_req, err);
    set_in(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // New fetch after reset completes with minimum latency
    step_in(1, 32'h300, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("post_c0_mem_req",  mem_req,  1'b0);
    chk("post_c0_if_stall", if_stall, 1'b1);
    step_in(1, 32'h300, 0, 0, 32'h0, 32'h0, 0, 1, 32'hABCD1234);
    chk("post_c1_mem_req",  mem_req,  1'b1);
    chk("post_c1_mem_addr", mem_addr, 32'h300);
    step_in(1, 32'h300, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("post_c2_if_valid", if_valid, 1'b1);
    chk("post_c2_if_rdata", if_rdata, 32'hABCD1234);
    chk("post_c2_err",      err,      1'b0);
    $display("post-reset fetch: if_valid=%0b if_rdata=0x%08h", if_valid, if_rdata);
    step_in(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("post_c3_if_valid", if_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-ported unified memory between instruction fetch (IF) and data memory access (DM) in the RISC-V pipeline. A 4-state FSM holds each transaction until the memory acknowledges it, then returns the response to the requester. It also drives the per-requester stall outputs back to the pipeline. Data has fixed priority over fetch, and a branch-taken flush cancels an in-flight fetch response.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max cycles in BUSY with mem_ready low before abort (4-bit counter, 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  AW  fetch address
if_rdata  out  DW  fetch data, registered
if_valid  out  1  one-cycle fetch completion pulse
if_stall  out  1  fetch stall to pipeline
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_valid
dm_we  in  1  1 = write, 0 = read
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data, registered
dm_valid  out  1  one-cycle data completion pulse
dm_stall  out  1  data stall to pipeline
flush  in  1  branch/jump taken (PCSrc); kills pending fetch
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid when mem_ready=1
mem_ready  in  1  memory acknowledge, one cycle
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including rdata regs, err, kill flag and timeout counter. An in-flight transaction is dropped and mem_req falls immediately.
- States: IDLE, BUSY_IF, BUSY_DM, DONE. A latched owner bit selects IF or DM.
- IDLE, dm_req=1: latch dm_we/dm_addr/dm_wdata, owner=DM, go BUSY_DM. Otherwise if if_req=1: latch if_addr, owner=IF, go BUSY_IF. DM wins on a tie.
- BUSY_*: mem_req=1 and mem_we/mem_addr/mem_wdata come from the latched values. mem_we is 0 in BUSY_IF.
- BUSY_*, mem_ready=1: capture mem_rdata (DM write captures 0 instead), mem_req 0 next cycle. Go DONE, or IDLE if owner=IF and kill=1.
- DONE: pulse the owner's valid for exactly one cycle with its registered rdata, then go IDLE. No acceptance in DONE, which prevents re-servicing a still-held req.
- Minimum latency: req sampled at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, valid at cycle 2, next acceptance at cycle 3.
- if_rdata/dm_rdata hold their value until the next completion for that owner.
- if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid (combinational from registered valid).
- flush=1 in BUSY_IF, or in the IDLE cycle that accepts IF: set kill. The memory transaction still completes, but there is no if_valid and DONE is skipped. kill clears on return to IDLE. Flush in DONE has no effect, and flush has no effect on DM.
- Timeout: counter increments each BUSY cycle with mem_ready=0 and clears on entry to BUSY. When it reaches TIMEOUT: set err, drop mem_req, rdata=0, go DONE (valid still pulses). err is cleared only by reset.
- mem_ready outside BUSY is ignored.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs perf_conflict (16 bit) and perf_wait (16 bit), both saturating at 16'hFFFF and reset to 0.
- perf_conflict counts IDLE cycles where if_req & dm_req are both 1.
- perf_wait counts cycles where if_stall | dm_stall is 1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. IF read alone: if_addr=0x100, mem_ready at cycle 1 with mem_rdata=0x00500093 -> mem_req=1 cycle 1 only; if_valid cycle 2 with if_rdata=0x00500093; if_stall=1 cycles 0-1.
2. Simultaneous if_req (0x104) and dm_req read (0x2000): mem_addr=0x2000 first and dm_valid first; then mem_addr=0x104 and if_valid; if_stall stays high throughout.
3. DM write dm_addr=0x2004, dm_wdata=0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D; dm_valid pulse with dm_rdata=0.
4. Fetch 0x108, flush=1 in cycle 1, mem_ready at cycle 3 -> no if_valid; FSM back in IDLE at cycle 4; a new fetch to 0x200 completes normally.
5. TIMEOUT=15, mem_ready held 0 -> after 15 BUSY cycles err=1, mem_req=0, valid pulse with rdata=0; err stays 1 until rst=0.
6. rst driven 0 mid BUSY_DM -> mem_req, valid and err are 0 immediately (asynchronously); after rst=1 the FSM is in IDLE and accepts a new request.
